seq_chunk_adder: RTL and testbench

- Parametrised multi-cycle ripple adder: it adds two WIDTH-bit operands plus carry-in, processing CHUNK bits per clock.
- Generalises the combinational 2-bit full-adder chain to arbitrary width.
- Adds a start/busy/done handshake, a registered result and signed-overflow detection.
- Sits in the datapath wherever a narrow adder slice is time-shared to produce a wide sum.

---
 rtl/seq_chunk_adder_if.sv | 24 ++
 rtl/seq_chunk_adder.sv | 112 +++++++++++
 tb/tb_seq_chunk_adder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_chunk_adder_if.sv
// rtl/seq_chunk_adder_if.sv - start/busy/done operand and result bundle for seq_chunk_adder
interface seq_chunk_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle ripple adder, CHUNK bits per clock, with signed overflow
module seq_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_chunk_adder_if.slave   bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [31:0]      shamt;
    logic [WIDTH-1:0] a_sh, b_sh, slice_mask, slice_val;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             msb_carry, last_chunk;

    always_comb begin
        shamt      = 32'(idx_q) * 32'(CHUNK);
        a_sh       = a_q >> shamt;
        b_sh       = b_q >> shamt;
        a_chunk    = a_sh[CHUNK-1:0];
        b_chunk    = b_sh[CHUNK-1:0];
        chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        // The sum bit is a^b^carry_in, so the carry into the chunk MSB falls out by XOR.
        msb_carry  = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
        slice_mask = WIDTH'({CHUNK{1'b1}}) << shamt;
        slice_val  = WIDTH'(chunk_sum[CHUNK-1:0]) << shamt;
        last_chunk = (idx_q == IDXW'(NCHUNK - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = (sum_q & ~slice_mask) | slice_val;
                carry_d = chunk_sum[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (last_chunk) begin
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = msb_carry ^ chunk_sum[CHUNK];
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - scoreboard bench for seq_chunk_adder at 8/2, 2/1 and 2/2
module tb_seq_chunk_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_chunk_adder_if #(.WIDTH(8)) i8  ();
    seq_chunk_adder_if #(.WIDTH(2)) i21 ();
    seq_chunk_adder_if #(.WIDTH(2)) i22 ();

    seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) u8  (.clk(clk), .rst_n(rst_n), .bus(i8));
    seq_chunk_adder #(.WIDTH(2), .CHUNK(1)) u21 (.clk(clk), .rst_n(rst_n), .bus(i21));
    seq_chunk_adder #(.WIDTH(2), .CHUNK(2)) u22 (.clk(clk), .rst_n(rst_n), .bus(i22));

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    exp_t q8[$];
    exp_t q21[$];
    exp_t q22[$];
    exp_t e8, e21, e22;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   done8_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b, input logic c);
        int   full;
        exp_t e;
        full   = int'(a) + int'(b) + int'(c);
        e.sum  = 8'(full & ((1 << w) - 1));
        e.cout = 1'((full >> w) & 1);
        e.ovf  = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
        return e;
    endfunction

    always @(negedge clk) begin
        if (i8.done) begin
            done8_cnt++;
            if (q8.size() == 0) check("w8 unexpected done", 32'(q8.size()), 1);
            else begin
                e8 = q8.pop_front();
                check("w8 sum", 32'(i8.sum), 32'(e8.sum));
                check("w8 cout", 32'(i8.cout), 32'(e8.cout));
                check("w8 overflow", 32'(i8.overflow), 32'(e8.ovf));
            end
        end
        if (i21.done) begin
            if (q21.size() == 0) check("w2c1 unexpected done", 32'(q21.size()), 1);
            else begin
                e21 = q21.pop_front();
                check("w2c1 sum", 32'(i21.sum), 32'(e21.sum));
                check("w2c1 cout", 32'(i21.cout), 32'(e21.cout));
                check("w2c1 overflow", 32'(i21.overflow), 32'(e21.ovf));
            end
        end
        if (i22.done) begin
            if (q22.size() == 0) check("w2c2 unexpected done", 32'(q22.size()), 1);
            else begin
                e22 = q22.pop_front();
                check("w2c2 sum", 32'(i22.sum), 32'(e22.sum));
                check("w2c2 cout", 32'(i22.cout), 32'(e22.cout));
                check("w2c2 overflow", 32'(i22.overflow), 32'(e22.ovf));
            end
        end
    end

    task automatic drain(input string name);
        for (int i = 0; i < 30 && (q8.size() + q21.size() + q22.size()) != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check(name, 32'(q8.size() + q21.size() + q22.size()), 0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input exp_t e);
        i8.a     = a;
        i8.b     = b;
        i8.cin   = c;
        i8.start = 1'b1;
        q8.push_back(e);
        @(posedge clk);
        #1;
        i8.start = 1'b0;
        drain("w8 op timeout");
    endtask

    vec_t vecs[7];
    exp_t e;
    int   base;

    initial begin
        vecs[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        vecs[6] = '{8'hC0, 8'h50, 1'b0, 8'h10, 1'b1, 1'b0};

        {i8.start, i8.a, i8.b, i8.cin}     = '0;
        {i21.start, i21.a, i21.b, i21.cin} = '0;
        {i22.start, i22.a, i22.b, i22.cin} = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(i8.busy), 0);
        check("reset done", 32'(i8.done), 0);
        check("reset sum", 32'(i8.sum), 0);
        check("reset cout", 32'(i8.cout), 0);
        check("reset overflow", 32'(i8.overflow), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: start at edge k, busy through k+4, done after k+4.
        i8.a = 8'h5A; i8.b = 8'h33; i8.cin = 1'b0; i8.start = 1'b1;
        q8.push_back('{8'h8D, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        i8.start = 1'b0;
        check("lat busy after accept", 32'(i8.busy), 1);
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk);
            #1;
            check("lat busy", 32'(i8.busy), (j < 4) ? 32'd1 : 32'd0);
            check("lat done", 32'(i8.done), (j < 4) ? 32'd0 : 32'd1);
        end
        drain("lat timeout");

        for (int v = 0; v < 7; v++)
            op8(vecs[v].a, vecs[v].b, vecs[v].cin, '{vecs[v].sum, vecs[v].cout, vecs[v].ovf});

        // Start held high: only operands at accepting edges (every 5th) count.
        base = done8_cnt;
        i8.start = 1'b1;
        for (int c = 0; c < 15; c++) begin
            i8.a   = 8'($urandom);
            i8.b   = 8'($urandom);
            i8.cin = 1'($urandom);
            if (c % 5 == 0) q8.push_back(model(8, i8.a, i8.b, i8.cin));
            @(posedge clk);
            #1;
        end
        i8.start = 1'b0;
        drain("b2b timeout");
        check("b2b done count", 32'(done8_cnt - base), 3);

        // Reset two edges into an operation aborts it.
        base = done8_cnt;
        i8.a = 8'hF0; i8.b = 8'h0F; i8.cin = 1'b0; i8.start = 1'b1;
        @(posedge clk);
        #1;
        i8.start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk);
            #1;
            check("abort busy", 32'(i8.busy), 0);
            check("abort done", 32'(i8.done), 0);
            check("abort sum", 32'(i8.sum), 0);
        end
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort no done", 32'(done8_cnt - base), 0);
        op8(8'hF0, 8'h0F, 1'b0, '{8'hFF, 1'b0, 1'b0});

        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++) begin
                    i21.a = 2'(a); i21.b = 2'(b); i21.cin = 1'(c); i21.start = 1'b1;
                    i22.a = 2'(a); i22.b = 2'(b); i22.cin = 1'(c); i22.start = 1'b1;
                    e = model(2, 8'(a), 8'(b), 1'(c));
                    q21.push_back(e);
                    q22.push_back(e);
                    @(posedge clk);
                    #1;
                    i21.start = 1'b0;
                    i22.start = 1'b0;
                    @(posedge clk);
                    #1;
                    check("w2c2 done one edge", 32'(i22.done), 1);
                    check("w2c1 busy mid", 32'(i21.busy), 1);
                    @(posedge clk);
                    #1;
                    check("w2c1 done two edges", 32'(i21.done), 1);
                    drain("sweep timeout");
                end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, total_cnt);
        $fatal(1);
    end
endmodule
